// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              halted,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [2:0] WAIT_LOAD  = 3'(RD_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t state_r, state_s;

  logic [2:0]        wait_cnt_r;
  logic [3:0]        starve_cnt_r;
  logic              is_fetch_r;
  logic              is_store_r;
  logic              flush_flag_r;
  logic              if_gnt_r, dm_gnt_r, if_rvalid_r, dm_rvalid_r;
  logic              mem_en_r, mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r, if_rdata_r, dm_rdata_r;

  logic if_elig_s, any_req_s, pick_if_s, flush_hit_s;

  assign if_elig_s   = if_req & ~halted;
  assign any_req_s   = dm_req | if_elig_s;
  assign pick_if_s   = if_elig_s & (~dm_req | (starve_cnt_r == STARVE_LIM));
  assign flush_hit_s = flush_flag_r | if_flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (any_req_s) state_s = ISSUE; else state_s = IDLE;
      ISSUE:   if (is_store_r) state_s = IDLE; else state_s = WAIT;
      WAIT:    if (wait_cnt_r == 3'd0) state_s = IDLE; else state_s = WAIT;
      default: state_s = IDLE;
    endcase
  end

  // Transaction datapath: winner latch, memory strobes, wait timer and read return
  always_ff @(posedge clk) begin
    if (rst) begin
      is_fetch_r   <= 1'b0;
      is_store_r   <= 1'b0;
      flush_flag_r <= 1'b0;
      wait_cnt_r   <= 3'd0;
      if_gnt_r     <= 1'b0;
      dm_gnt_r     <= 1'b0;
      if_rvalid_r  <= 1'b0;
      dm_rvalid_r  <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      if_rdata_r   <= '0;
      dm_rdata_r   <= '0;
    end else begin
      if_gnt_r    <= 1'b0;
      dm_gnt_r    <= 1'b0;
      if_rvalid_r <= 1'b0;
      dm_rvalid_r <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            is_fetch_r   <= pick_if_s;
            is_store_r   <= ~pick_if_s & dm_we;
            flush_flag_r <= 1'b0;
            if_gnt_r     <= pick_if_s;
            dm_gnt_r     <= ~pick_if_s;
            mem_en_r     <= 1'b1;
            mem_we_r     <= ~pick_if_s & dm_we;
            mem_addr_r   <= pick_if_s ? if_addr : dm_addr;
            if (!pick_if_s) mem_wdata_r <= dm_wdata;
          end
        end
        ISSUE: begin
          wait_cnt_r <= WAIT_LOAD;
          if (is_fetch_r && if_flush) flush_flag_r <= 1'b1;
        end
        WAIT: begin
          if (is_fetch_r && if_flush) flush_flag_r <= 1'b1;
          if (wait_cnt_r == 3'd0) begin
            // A flushed fetch still completes at the memory but is never returned.
            if (is_fetch_r) begin
              if_rvalid_r <= ~flush_hit_s;
              if (!flush_hit_s) if_rdata_r <= mem_rdata;
            end else begin
              dm_rvalid_r <= 1'b1;
              dm_rdata_r  <= mem_rdata;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
          end
        end
        default: begin
          flush_flag_r <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter: counts data wins while a fetch is waiting
  always_ff @(posedge clk) begin
    if (rst || !if_elig_s) begin
      starve_cnt_r <= 4'd0;
    end else if (state_r == IDLE && any_req_s) begin
      if (pick_if_s)                     starve_cnt_r <= 4'd0;
      else if (starve_cnt_r < STARVE_LIM) starve_cnt_r <= starve_cnt_r + 4'd1;
      else                               starve_cnt_r <= starve_cnt_r;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // A flush in the return cycle itself must still kill the pulse.
  assign if_rvalid = if_rvalid_r & ~if_flush;
  assign if_gnt    = if_gnt_r;
  assign if_rdata  = if_rdata_r;
  assign dm_gnt    = dm_gnt_r;
  assign dm_rvalid = dm_rvalid_r;
  assign dm_rdata  = dm_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small RD_LAT=2 memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, dm_req, dm_we, halted;
  logic [9:0]  if_addr, dm_addr;
  logic [31:0] dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_en, mem_we, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .halted(halted),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: fixed read contents, two-cycle read latency, stores recorded
  logic [9:0]  a_d1, a_d2;
  logic [9:0]  wr_addr_seen;
  logic [31:0] wr_data_seen;

  function automatic logic [31:0] rom(input logic [9:0] a);
    case (a)
      10'd5:   rom = 32'h2800000A;
      10'd7:   rom = 32'hCAFE0007;
      10'd9:   rom = 32'h00001234;
      default: rom = 32'hDEAD0000 | {22'd0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    a_d1 <= mem_addr;
    a_d2 <= a_d1;
    if (mem_en && mem_we) begin
      wr_addr_seen <= mem_addr;
      wr_data_seen <= mem_wdata;
    end
  end
  assign mem_rdata = rom(a_d2);

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = 10'd0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 10'd0; dm_wdata = 32'd0;
    halted = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int ng;
    logic [7:0] seq;

    // Reset state and basic fetch
    do_reset();
    check_val("reset_outputs",
              {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy},
              64'd0);
    if_req = 1'b1; if_addr = 10'd5;
    tick();
    check_val("fetch_issue", {if_gnt, dm_gnt, mem_en, mem_we, busy}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    check_val("fetch_addr", mem_addr, 10'd5);
    if_req = 1'b0;
    tick();
    check_val("fetch_c1", {if_gnt, mem_en, mem_we, if_rvalid}, 4'b0000);
    check_val("fetch_addr_hold", mem_addr, 10'd5);
    tick();
    check_val("fetch_c2_rvalid", if_rvalid, 1'b0);
    tick();
    check_val("fetch_c3_rvalid", {if_rvalid, busy}, 2'b10);
    check_val("fetch_c3_rdata", if_rdata, 32'h2800000A);
    tick();
    check_val("fetch_rdata_hold", {if_rvalid, if_rdata}, {1'b0, 32'h2800000A});

    // Store and fetch contending: store first, fetch in C+2
    do_reset();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd20; dm_wdata = 32'h55;
    if_req = 1'b1; if_addr = 10'd3;
    tick();
    check_val("store_gnt", {dm_gnt, if_gnt, mem_en, mem_we}, 4'b1011);
    check_val("store_addr_data", {mem_addr, mem_wdata}, {10'd20, 32'h55});
    dm_req = 1'b0;
    tick();
    check_val("store_c1", {dm_gnt, if_gnt, mem_en, mem_we, dm_rvalid, busy}, 6'b000000);
    check_val("store_written", {wr_addr_seen, wr_data_seen}, {10'd20, 32'h55});
    tick();
    check_val("fetch_after_store", {if_gnt, mem_en, mem_we}, 3'b110);
    check_val("fetch_after_store_addr", {mem_addr, mem_wdata}, {10'd3, 32'h55});
    if_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); cnt += int'(dm_rvalid); end
    check_val("store_no_rvalid", cnt, 0);

    // Starvation: both requesters held continuously
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd1;
    if_req = 1'b1; if_addr = 10'd2;
    seq = 8'd0; ng = 0;
    for (int i = 0; i < 60 && ng < 8; i++) begin
      tick();
      if (dm_gnt || if_gnt) begin
        seq = {seq[6:0], if_gnt};
        ng++;
      end
    end
    check_val("starve_count", ng, 8);
    check_val("starve_order", seq, 8'b0001_0001);
    dm_req = 1'b0; if_req = 1'b0;

    // Flush in C+1 suppresses return; next fetch completes
    do_reset();
    if_req = 1'b1; if_addr = 10'd9;
    tick();
    check_val("flush_fetch_gnt", if_gnt, 1'b1);
    if_req = 1'b0;
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); cnt += int'(if_rvalid); end
    check_val("flush_no_rvalid", cnt, 0);
    check_val("flush_rdata_hold", if_rdata, 32'd0);
    if_req = 1'b1;
    tick();
    check_val("refetch_gnt", if_gnt, 1'b1);
    if_req = 1'b0;
    tick(); tick(); tick();
    check_val("refetch_rvalid", {if_rvalid, if_rdata}, {1'b1, 32'h00001234});

    // Halted: only data traffic; flush during a load is ignored
    do_reset();
    halted = 1'b1; if_req = 1'b1; if_addr = 10'd4;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd7;
    tick();
    cnt = int'(if_gnt);
    check_val("halted_dm_gnt", {dm_gnt, mem_en, mem_we}, 3'b110);
    dm_req = 1'b0;
    if_flush = 1'b1;
    tick(); cnt += int'(if_gnt);
    if_flush = 1'b0;
    tick(); cnt += int'(if_gnt);
    tick(); cnt += int'(if_gnt);
    check_val("halted_dm_rvalid", {dm_rvalid, dm_rdata}, {1'b1, 32'hCAFE0007});
    for (int i = 0; i < 10; i++) begin tick(); cnt += int'(if_gnt) + int'(busy); end
    check_val("halted_no_if_gnt", cnt, 0);
    if_req = 1'b0; halted = 1'b0;

    // Halt rising mid-fetch does not cancel it
    do_reset();
    if_req = 1'b1; if_addr = 10'd5;
    tick();
    check_val("halt_mid_gnt", if_gnt, 1'b1);
    if_req = 1'b0; halted = 1'b1;
    tick(); tick(); tick();
    check_val("halt_mid_rvalid", {if_rvalid, if_rdata}, {1'b1, 32'h2800000A});
    halted = 1'b0;

    // Reset in C+1 of a load discards it
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd7;
    tick();
    check_val("rst_load_gnt", dm_gnt, 1'b1);
    dm_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_val("rst_mid_outputs",
              {dm_gnt, dm_rvalid, dm_rdata, if_gnt, if_rvalid, mem_en, mem_we, mem_addr, mem_wdata, busy},
              64'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); cnt += int'(dm_rvalid) + int'(busy); end
    check_val("rst_no_rvalid", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
